register8bit_serializer: RTL and testbench

- Parallel-in, serial-out reader for the 8-bit register datapath.
- Takes a word from a register's `q` bus through a valid/ready load handshake.
- Shifts the word out one bit per accepted transfer on a serial valid/ready channel, with a last-bit flag and a completion pulse.
- Sits after `register8bit`-style storage and feeds bit-serial consumers such as the shift-and-add multiplier datapath.

---
 rtl/register8bit_serializer.sv | 88 ++++++++
 tb/tb_register8bit_serializer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register8bit_serializer.sv
// Parallel-in, serial-out reader: accepts a WIDTH-bit word over a valid/ready
// load handshake and shifts it out one bit per accepted serial transfer.
module register8bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             done_nxt;
  logic             ser_acc;
  logic             load_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    busy       = (state == SHIFT);
    ser_valid  = busy;
    last       = busy && (cnt == CNT_LAST);
    ser_out    = busy && (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
    // Ready during the last-bit accept lets the next word follow with no bubble.
    load_ready = !busy || (last && ser_ready);
    ser_acc    = ser_valid && ser_ready;
    load_acc   = load_valid && load_ready;

    state_nxt  = state;
    sreg_nxt   = sreg;
    cnt_nxt    = cnt;
    done_nxt   = 1'b0;

    if (ser_acc) begin
      if (last) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
        sreg_nxt  = '0;
        cnt_nxt   = '0;
      end else begin
        if (MSB_FIRST) begin
          sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
        end else begin
          sreg_nxt = {1'b0, sreg[WIDTH-1:1]};
        end
        cnt_nxt = cnt + 1'b1;
      end
    end

    // A load coinciding with the last-bit accept overrides the return to IDLE.
    if (load_acc) begin
      state_nxt = SHIFT;
      sreg_nxt  = din;
      cnt_nxt   = '0;
    end
  end

endmodule

// File: tb/tb_register8bit_serializer.sv
// Scoreboard bench for register8bit_serializer: an LSB-first and an MSB-first
// instance share clock and reset; expected bits are queued at load time.
module tb_register8bit_serializer;

  typedef struct packed {
    logic b;
    logic l;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [7:0] din [2];
  logic [1:0] load_valid;
  logic [1:0] ser_ready;
  logic [1:0] load_ready;
  logic [1:0] ser_out;
  logic [1:0] ser_valid;
  logic [1:0] last;
  logic [1:0] busy;
  logic [1:0] done;

  int unsigned errors = 0;
  int unsigned checks = 0;

  exp_t qa[$];
  exp_t qb[$];
  logic [1:0]  exp_done = '0;
  int unsigned vcnt[2]   = '{0, 0};
  int unsigned dcnt[2]   = '{0, 0};
  int unsigned run[2]    = '{0, 0};
  int unsigned endrun[2] = '{0, 0};

  register8bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset_n(reset_n), .din(din[0]), .load_valid(load_valid[0]),
    .load_ready(load_ready[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .last(last[0]), .busy(busy[0]), .done(done[0])
  );

  register8bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset_n(reset_n), .din(din[1]), .load_valid(load_valid[1]),
    .load_ready(load_ready[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .last(last[1]), .busy(busy[1]), .done(done[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int unsigned qsz(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  // Scoreboard consumer: pops one expected bit per accepted serial transfer.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned n;
    if (!reset_n) begin
      qa.delete();
      qb.delete();
      exp_done = '0;
      run = '{0, 0};
    end else begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("done[%0d]", d), 32'(done[d]), 32'(exp_done[d]));
        exp_done[d] = 1'b0;
        if (done[d]) dcnt[d]++;
        if (ser_valid[d]) begin
          vcnt[d]++;
          run[d]++;
        end else begin
          if (run[d] != 0) endrun[d] = run[d];
          run[d] = 0;
        end
        if (ser_valid[d] && ser_ready[d]) begin
          n = qsz(d);
          check($sformatf("sb_nonempty[%0d]", d), 32'(n != 0), 32'd1);
          if (n != 0) begin
            if (d == 0) e = qa.pop_front();
            else        e = qb.pop_front();
            check($sformatf("ser_out[%0d]", d), 32'(ser_out[d]), 32'(e.b));
            check($sformatf("last[%0d]", d), 32'(last[d]), 32'(e.l));
            if (e.l) exp_done[d] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input int d, input logic [7:0] w, input bit keep);
    int   k = 0;
    exp_t e;
    din[d] = w;
    load_valid[d] = 1'b1;
    while (!load_ready[d] && k < 40) begin
      tick(1);
      k++;
    end
    check($sformatf("load_ready[%0d]", d), 32'(load_ready[d]), 32'd1);
    for (int i = 0; i < 8; i++) begin
      e.b = (d == 0) ? w[i] : w[7-i];
      e.l = (i == 7);
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
    tick(1);
    if (!keep) load_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    int k = 0;
    while (qsz(d) != 0 && k < 40) begin
      tick(1);
      k++;
    end
    check($sformatf("drain[%0d]", d), qsz(d), 32'd0);
  endtask

  initial begin
    int unsigned v0, d0, d1;
    reset_n    = 1'b1;
    load_valid = '0;
    ser_ready  = '0;
    din[0]     = 8'h00;
    din[1]     = 8'h00;

    // Asynchronous reset, observed before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("rst ser_valid", 32'(ser_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst load_ready", 32'(load_ready), 32'h3);
    check("rst ser_out", 32'(ser_out), 32'd0);
    check("rst last", 32'(last), 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;

    // ser_ready while idle has no effect
    ser_ready = 2'b11;
    tick(2);
    check("idle ser_ready busy", 32'(busy), 32'd0);

    // Basic LSB-first word
    v0 = vcnt[0];
    d0 = dcnt[0];
    load(0, 8'hA5, 1'b0);
    drain(0);
    tick(2);
    check("A5 busy", 32'(busy[0]), 32'd0);
    check("A5 valid cycles", vcnt[0] - v0, 32'd8);
    check("A5 done count", dcnt[0] - d0, 32'd1);

    // Backpressure: stall three cycles with bit 2 presented
    v0 = vcnt[0];
    load(0, 8'hC3, 1'b0);
    tick(2);
    ser_ready[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("C3 hold ser_out", 32'(ser_out[0]), 32'd0);
      check("C3 hold valid", 32'(ser_valid[0]), 32'd1);
      check("C3 hold last", 32'(last[0]), 32'd0);
      @(posedge clk);
      #1;
    end
    ser_ready[0] = 1'b1;
    drain(0);
    tick(2);
    check("C3 valid cycles", vcnt[0] - v0, 32'd11);

    // Back-to-back words with load_valid held
    v0 = vcnt[0];
    d0 = dcnt[0];
    load(0, 8'h3C, 1'b1);
    load(0, 8'hF0, 1'b0);
    drain(0);
    tick(2);
    check("b2b run length", endrun[0], 32'd16);
    check("b2b valid cycles", vcnt[0] - v0, 32'd16);
    check("b2b done count", dcnt[0] - d0, 32'd2);

    // MSB-first instance
    d1 = dcnt[1];
    load(1, 8'h81, 1'b0);
    drain(1);
    load(1, 8'h40, 1'b0);
    drain(1);
    tick(2);
    check("msb done count", dcnt[1] - d1, 32'd2);
    check("msb busy", 32'(busy[1]), 32'd0);

    // Ignored load during a word, then reset after three bits
    d0 = dcnt[0];
    load(0, 8'h96, 1'b0);
    tick(1);
    load_valid[0] = 1'b1;
    din[0]        = 8'hFF;
    check("ignored load_ready", 32'(load_ready[0]), 32'd0);
    tick(1);
    load_valid[0] = 1'b0;
    check("96 bit2", 32'(ser_out[0]), 32'd1);
    tick(1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst ser_valid", 32'(ser_valid[0]), 32'd0);
    check("midrst busy", 32'(busy[0]), 32'd0);
    check("midrst ser_out", 32'(ser_out[0]), 32'd0);
    check("midrst last", 32'(last[0]), 32'd0);
    check("midrst done", 32'(done[0]), 32'd0);
    check("midrst load_ready", 32'(load_ready[0]), 32'd1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    load(0, 8'h01, 1'b0);
    drain(0);
    tick(2);
    check("post-reset done count", dcnt[0] - d0, 32'd1);
    check("post-reset busy", 32'(busy[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
